// File: rtl/stream_mux_pkg.sv
// Shared types for the N:1 stream multiplexer.
package stream_mux_pkg;

  // Channel selection policy, driven on the mode port.
  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Packet framing state: LOCKED while a multi-beat packet is in flight.
  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin search: first requester at or above ptr, wrapping at N-1.
module rr_arbiter_n #(
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    int unsigned j;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr) + k;
      if (j >= N) j = j - N;
      if (!gnt_any && req[j[SEL_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = j[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_mux_nto1.sv
// Registered N:1 valid/ready stream mux with fixed or round-robin selection and
// packet locking so multi-beat packets are never interleaved.
module stream_mux_nto1
  import stream_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   grant_idx,
  output logic               locked
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]   grant_q, grant_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;

  logic [SEL_W-1:0]   arb_idx;
  logic               arb_any;
  logic               sel_in_range;
  logic [SEL_W-1:0]   sel_idx;
  logic [SEL_W-1:0]   cand;
  logic               cand_ok;
  logic               load_en;
  logic               accept;
  logic [WIDTH-1:0]   cand_data;

  rr_arbiter_n #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  // Candidate channel: frozen grant while locked, otherwise per mode.
  always_comb begin
    sel_in_range = (32'(sel) < N);
    sel_idx      = sel_in_range ? sel : '0;
    cand         = '0;
    cand_ok      = 1'b0;
    if (state_q == LOCKED) begin
      cand    = grant_q;
      cand_ok = in_valid[grant_q];
    end else if (mode == MODE_RR) begin
      cand    = arb_idx;
      cand_ok = arb_any;
    end else begin
      cand    = sel_idx;
      cand_ok = sel_in_range && in_valid[sel_idx];
    end
  end

  // Output register can load when empty or draining this cycle.
  always_comb begin
    load_en   = !out_valid_q || out_ready;
    accept    = load_en && cand_ok;
    cand_data = in_data[32'(cand)*WIDTH +: WIDTH];
    in_ready  = '0;
    // Gated by rst_n so no channel sees ready while reset is held.
    if (accept && rst_n) in_ready[cand] = 1'b1;
  end

  // Next-state for lock FSM, rr pointer and output register.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = cand_data;
      out_last_d  = in_last[cand];
      grant_d     = cand;
      if (in_last[cand]) begin
        state_d  = UNLOCKED;
        rr_ptr_d = (cand == SEL_W'(N - 1)) ? '0 : cand + 1'b1;
      end else begin
        state_d = LOCKED;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNLOCKED;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign grant_idx = grant_q;
  assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Randomized bench for stream_mux_nto1 against a behavioural packet-level model.
module tb_stream_mux_nto1;

  localparam int WIDTH = 16;
  localparam int N     = 4;
  localparam int SEL_W = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_last;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic               out_ready;
  logic [SEL_W-1:0]   grant_idx;
  logic               locked;

  // Second instance with N=3 for the out-of-range select case.
  logic               mode3;
  logic [1:0]         sel3;
  logic [2:0]         in_valid3;
  logic [3*WIDTH-1:0] in_data3;
  logic [2:0]         in_last3;
  logic [2:0]         in_ready3;
  logic               out_valid3;
  logic [WIDTH-1:0]   out_data3;
  logic               out_last3;
  logic               out_ready3;
  logic [1:0]         grant_idx3;
  logic               locked3;

  always #5 clk = ~clk;

  stream_mux_nto1 #(.WIDTH(WIDTH), .N(N)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant_idx (grant_idx),
    .locked    (locked)
  );

  stream_mux_nto1 #(.WIDTH(WIDTH), .N(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode3),
    .sel       (sel3),
    .in_valid  (in_valid3),
    .in_data   (in_data3),
    .in_last   (in_last3),
    .in_ready  (in_ready3),
    .out_valid (out_valid3),
    .out_data  (out_data3),
    .out_last  (out_last3),
    .out_ready (out_ready3),
    .grant_idx (grant_idx3),
    .locked    (locked3)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the mux is holding, which packet owns it, where RR resumes.
  bit          m_valid;
  bit [15:0]   m_data;
  bit          m_last;
  int          m_grant;
  bit          m_in_packet;
  int          m_next_rr;
  int          dut_gnt[$];
  bit          dut_lock[$];

  function automatic void model_reset();
    m_valid     = 0;
    m_data      = '0;
    m_last      = 0;
    m_grant     = 0;
    m_in_packet = 0;
    m_next_rr   = 0;
  endfunction

  // Which channel would the mux take from, if any.
  function automatic void model_pick(output int c, output bit ok);
    c  = 0;
    ok = 0;
    if (m_in_packet) begin
      c  = m_grant;
      ok = in_valid[m_grant];
    end else if (mode == 1'b0) begin
      c  = int'(sel);
      ok = (c < N) && in_valid[c];
    end else begin
      for (int k = 0; k < N; k++) begin
        int ch;
        ch = (m_next_rr + k) % N;
        if (!ok && in_valid[ch]) begin
          ok = 1;
          c  = ch;
        end
      end
    end
  endfunction

  function automatic logic [15:0] chan_data(input int c);
    logic [N*WIDTH-1:0] d;
    d = in_data;
    return d[c*WIDTH +: WIDTH];
  endfunction

  // Call after inputs are driven (post negedge); checks ready, clocks, checks registers.
  task automatic step();
    int  c;
    bit  ok;
    bit  can_take;
    logic [N-1:0] exp_rdy;
    #1;
    model_pick(c, ok);
    can_take = !m_valid || out_ready;
    exp_rdy  = '0;
    if (can_take && ok) exp_rdy[c] = 1'b1;
    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (can_take && ok) begin
      m_valid = 1;
      m_data  = chan_data(c);
      m_last  = in_last[c];
      m_grant = c;
      if (in_last[c]) begin
        m_in_packet = 0;
        m_next_rr   = (c + 1) % N;
      end else begin
        m_in_packet = 1;
      end
    end else if (out_ready) begin
      m_valid = 0;
    end
    #1;
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check_eq("out_data", 32'(out_data), 32'(m_data));
      check_eq("out_last", 32'(out_last), 32'(m_last));
    end
    check_eq("grant_idx", 32'(grant_idx), 32'(m_grant));
    check_eq("locked", 32'(locked), 32'(m_in_packet));
    dut_gnt.push_back(int'(grant_idx));
    dut_lock.push_back(locked);
  endtask

  task automatic set_data(input int c, input logic [15:0] v);
    in_data[c*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; in_last = '0;
    out_ready = 1'b0;
    mode3 = 1'b0; sel3 = '0; in_valid3 = '0; in_data3 = '0; in_last3 = '0; out_ready3 = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_data", 32'(out_data), 0);
    check_eq("rst_grant", 32'(grant_idx), 0);
    check_eq("rst_locked", 32'(locked), 0);
    in_valid = 4'b1111;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin fairness with single-beat packets.
    mode = 1'b1; in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_data(i, 16'(16'h1000 + i));
    dut_gnt.delete();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      step();
    end
    for (int i = 0; i < 8; i++) check_eq("rr_order", 32'(dut_gnt[i]), 32'(i % 4));

    // Move rr pointer to 1, then ch1 sends a 3-beat packet with ch0/ch2 competing.
    @(negedge clk);
    in_valid = 4'b0001;
    step();
    @(negedge clk);
    in_valid = 4'b0111;
    dut_gnt.delete();
    dut_lock.delete();
    for (int b = 0; b < 4; b++) begin
      if (b > 0) @(negedge clk);
      in_last = (b >= 2) ? 4'b1111 : 4'b1101;
      set_data(1, 16'(16'hA100 + b));
      step();
    end
    check_eq("lock_g0", 32'(dut_gnt[0]), 1);
    check_eq("lock_g1", 32'(dut_gnt[1]), 1);
    check_eq("lock_g2", 32'(dut_gnt[2]), 1);
    check_eq("lock_g3", 32'(dut_gnt[3]), 2);
    check_eq("lock_l0", 32'(dut_lock[0]), 1);
    check_eq("lock_l1", 32'(dut_lock[1]), 1);
    check_eq("lock_l2", 32'(dut_lock[2]), 0);

    // Fixed select of channel 2.
    @(negedge clk);
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; in_last = 4'b1111;
    set_data(2, 16'hBEEF);
    #1;
    check_eq("fix_rdy", 32'(in_ready), 32'h4);
    step();
    check_eq("fix_data", 32'(out_data), 32'hBEEF);
    check_eq("fix_grant", 32'(grant_idx), 2);

    // Backpressure for 5 cycles, then release.
    @(negedge clk);
    out_ready = 1'b0; sel = 2'd0; set_data(0, 16'h0C0C);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      step();
    end
    @(negedge clk);
    out_ready = 1'b1; sel = 2'd3; set_data(3, 16'h3333);
    step();

    // Reset while locked and holding a beat.
    @(negedge clk);
    mode = 1'b1; in_valid = 4'b0010; in_last = 4'b0000; out_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    step();
    @(negedge clk);
    out_ready = 1'b0;
    step();
    check_eq("pre_rst_locked", 32'(locked), 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_out_valid", 32'(out_valid), 0);
    check_eq("arst_locked", 32'(locked), 0);
    check_eq("arst_grant", 32'(grant_idx), 0);
    check_eq("arst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
    step();
    check_eq("post_rst_rr0", 32'(grant_idx), 0);

    // N=3: select 3 is out of range, select 2 works.
    @(negedge clk);
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; in_last3 = 3'b111; out_ready3 = 1'b1;
    in_data3 = {16'h2222, 16'h1111, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("oor_rdy", 32'(in_ready3), 0);
      @(posedge clk);
      #1;
      check_eq("oor_valid", 32'(out_valid3), 0);
      @(negedge clk);
    end
    sel3 = 2'd2;
    #1;
    check_eq("n3_rdy", 32'(in_ready3), 32'h4);
    @(posedge clk);
    #1;
    check_eq("n3_data", 32'(out_data3), 32'h2222);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom) | 4'($urandom);
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
